uart_rx_param: RTL and testbench

Parametrised UART receiver that succeeds the fixed 8N1 receiver. It adds:
- configurable data width;
- optional even/odd parity;
- 16x oversampling with 3-sample majority vote;
- per-word framing and parity error flags;
- a small first-word-fall-through receive FIFO with overrun detection.

It sits between the `uart_rx` pin and the system-side consumer, with the same `sysclk` domain and `Baud_set` encoding.

---
 rtl/uart_pkg.sv | 52 +++++
 rtl/uart_rx_fifo.sv | 61 ++++++
 rtl/uart_rx_param.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and helpers for the parametrised UART
//               receiver: FSM state encoding, parity modes, oversampling
//               constants and the baud divisor function.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Oversampling: 16 ticks per bit, majority of ticks 7/8/9
    localparam int               c_OVERSAMPLE = 16;
    localparam int               c_OS_W       = $clog2(c_OVERSAMPLE);
    localparam logic [c_OS_W-1:0] c_SAMPLE_T0 = 4'd7;
    localparam logic [c_OS_W-1:0] c_SAMPLE_T1 = 4'd8;
    localparam logic [c_OS_W-1:0] c_SAMPLE_T2 = 4'd9;

    // Width of the per-tick sysclk divisor
    localparam int c_DIV_W = 16;

    // Parity modes
    localparam logic [1:0] c_PAR_NONE     = 2'd0;
    localparam logic [1:0] c_PAR_EVEN     = 2'd1;
    localparam logic [1:0] c_PAR_ODD      = 2'd2;
    localparam logic [1:0] c_PAR_NONE_ALT = 2'd3;

    // Receiver FSM state encoding
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // sysclk cycles per oversample tick, rounded to nearest
    function automatic logic [c_DIV_W-1:0] baud_div(input int unsigned clk_freq,
                                                   input logic [2:0]  sel);
        int unsigned baud;
        case (sel)
            3'd1:    baud = 57600;
            3'd2:    baud = 38400;
            3'd3:    baud = 19200;
            3'd4:    baud = 9600;
            3'd5:    baud = 230400;
            3'd6:    baud = 460800;
            default: baud = 115200;
        endcase
        return c_DIV_W'((clk_freq + 8 * baud) / (16 * baud));
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Small first-word-fall-through FIFO. Synchronous write,
//               combinational head read gated to zero when empty. Full and
//               empty come from pointers carrying one extra wrap bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int             c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW:0]    wptr_q;
    logic [c_AW:0]    rptr_q;
    logic             w_do_rd;
    logic             w_do_wr;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[c_AW] != rptr_q[c_AW]) &&
                     (wptr_q[c_AW-1:0] == rptr_q[c_AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // write when it is being read.
    assign w_do_rd = rd_en_i && !empty_o;
    assign w_do_wr = wr_en_i && (!full_o || w_do_rd);

    // Pointer update; reset empties the FIFO
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_do_wr) wptr_q <= wptr_q + c_PTR_ONE;
            if (w_do_rd) rptr_q <= rptr_q + c_PTR_ONE;
        end
    end

    // Storage; contents are never observed while empty so no reset is needed
    always_ff @(posedge sysclk) begin
        if (w_do_wr) mem_q[wptr_q[c_AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rptr_q[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised UART receiver: 2-FF input synchroniser, 16x
//               oversampling tick generator with 3-sample majority vote,
//               optional even/odd parity, framing/parity error flags and a
//               FWFT receive FIFO with sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic [2:0]        Baud_set,
    input  logic [1:0]        parity_mode,
    input  logic              uart_rx,
    input  logic              rd_en,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] Data,
    output logic              frame_err,
    output logic              parity_err,
    output logic              rx_valid,
    output logic              rx_done,
    output logic              overrun
);

    localparam int c_WORD_W = DATA_W + 2;

    // Registered state
    logic [1:0]          sync_q;
    logic                prev_q;
    logic [2:0]          state_q,    state_d;
    logic [c_DIV_W-1:0]  div_q,      div_d;
    logic [c_DIV_W-1:0]  cnt_q,      cnt_d;
    logic [c_OS_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]          bit_cnt_q,  bit_cnt_d;
    logic [1:0]          samp_q,     samp_d;
    logic [DATA_W-1:0]   shift_q,    shift_d;
    logic                perr_q,     perr_d;
    logic [1:0]          pmode_q,    pmode_d;
    logic                done_q;
    logic                overrun_q,  overrun_d;

    // Combinational helpers
    logic                w_line;
    logic                w_start;
    logic                w_tick;
    logic                w_mid;
    logic                w_bit;
    logic                w_par_en;
    logic                w_stop_done;
    logic                w_ferr;
    logic                w_full;
    logic                w_empty;
    logic [c_WORD_W-1:0] w_head;

    assign w_line      = sync_q[1];
    assign w_start     = (state_q == c_ST_IDLE) && prev_q && !w_line;
    assign w_tick      = (cnt_q == div_q - c_DIV_W'(1));
    assign w_mid       = w_tick && (tick_cnt_q == c_SAMPLE_T2);
    // Majority of ticks 7, 8 and the live sample at tick 9
    assign w_bit       = (samp_q[0] & samp_q[1]) | (samp_q[0] & w_line) |
                         (samp_q[1] & w_line);
    assign w_par_en    = !((pmode_q == c_PAR_NONE) || (pmode_q == c_PAR_NONE_ALT));
    assign w_stop_done = (state_q == c_ST_STOP) && w_mid;
    assign w_ferr      = !w_bit;

    // Next-state logic: tick generation, sampling and frame FSM
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        pmode_d    = pmode_q;

        if (state_q != c_ST_IDLE) begin
            cnt_d = w_tick ? '0 : cnt_q + c_DIV_W'(1);
            if (w_tick) begin
                tick_cnt_d = tick_cnt_q + c_OS_W'(1);
                if (tick_cnt_q == c_SAMPLE_T0) samp_d[0] = w_line;
                if (tick_cnt_q == c_SAMPLE_T1) samp_d[1] = w_line;
            end
        end

        case (state_q)
            c_ST_IDLE: begin
                if (w_start) begin
                    // Baud and parity mode are frozen for the whole frame
                    state_d    = c_ST_START;
                    div_d      = baud_div(CLK_FREQ, Baud_set);
                    pmode_d    = parity_mode;
                    cnt_d      = '0;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    perr_d     = 1'b0;
                end
            end
            c_ST_START: begin
                if (w_mid) state_d = w_bit ? c_ST_IDLE : c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_mid) begin
                    shift_d   = {w_bit, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_W - 1))
                        state_d = w_par_en ? c_ST_PARITY : c_ST_STOP;
                end
            end
            c_ST_PARITY: begin
                if (w_mid) begin
                    perr_d  = (^shift_q) ^ w_bit ^ (pmode_q == c_PAR_ODD);
                    state_d = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                // Leave at mid-stop so a following start edge is not missed
                if (w_mid) state_d = c_ST_IDLE;
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // A completed frame while full is dropped unless a pop frees a slot
    // in the same cycle; a new drop wins over a concurrent clear.
    always_comb begin
        overrun_d = (overrun_q && !clr_ovr) || (w_stop_done && w_full && !rd_en);
    end

    // Synchroniser, FSM and status registers
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            sync_q     <= 2'b11;
            prev_q     <= 1'b1;
            state_q    <= c_ST_IDLE;
            div_q      <= baud_div(CLK_FREQ, 3'd0);
            cnt_q      <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= 2'b11;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            pmode_q    <= c_PAR_NONE;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], uart_rx};
            prev_q     <= sync_q[1];
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            pmode_q    <= pmode_d;
            done_q     <= w_stop_done;
            overrun_q  <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk    (sysclk),
        .rst       (rst),
        .wr_en_i   (w_stop_done),
        .wr_data_i ({w_ferr, perr_q, shift_q}),
        .rd_en_i   (rd_en),
        .rd_data_o (w_head),
        .full_o    (w_full),
        .empty_o   (w_empty)
    );

    assign Data       = w_head[DATA_W-1:0];
    assign parity_err = w_head[DATA_W];
    assign frame_err  = w_head[DATA_W+1];
    assign rx_valid   = !w_empty;
    assign rx_done    = done_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Directed self-checking bench for uart_rx_param at 50 MHz.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam realtime c_BT0 = 8680.0;
    localparam realtime c_BT4 = 104167.0;

    logic       sysclk      = 1'b0;
    logic       rst         = 1'b1;
    logic [2:0] Baud_set    = 3'd0;
    logic [1:0] parity_mode = 2'd0;
    logic       uart_rx     = 1'b1;
    logic       rd_en       = 1'b0;
    logic       clr_ovr     = 1'b0;
    logic [7:0] Data;
    logic       frame_err, parity_err, rx_valid, rx_done, overrun;

    int   tests = 0;
    int   fails = 0;
    int   done_hi = 0;
    int   done_rise = 0;
    logic done_prev = 1'b0;

    uart_rx_param #(
        .CLK_FREQ   (50_000_000),
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .Baud_set    (Baud_set),
        .parity_mode (parity_mode),
        .uart_rx     (uart_rx),
        .rd_en       (rd_en),
        .clr_ovr     (clr_ovr),
        .Data        (Data),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .rx_valid    (rx_valid),
        .rx_done     (rx_done),
        .overrun     (overrun)
    );

    always #10 sysclk = ~sysclk;

    // Count cycles rx_done is high and its rising edges
    always @(posedge sysclk) begin
        if (rx_done) done_hi++;
        if (rx_done && !done_prev) done_rise++;
        done_prev = rx_done;
    end

    // Serial frame driver; line is left at the stop-bit level
    task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par_bit,
                              input logic stop_bit, input realtime bt);
        uart_rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            #(bt);
        end
        if (par_en) begin
            uart_rx = par_bit;
            #(bt);
        end
        uart_rx = stop_bit;
        #(bt);
    endtask

    task automatic do_pop();
        @(negedge sysclk);
        rd_en = 1'b1;
        @(negedge sysclk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        #5 rst = 1'b0;
        repeat (3) @(negedge sysclk);
        tests++; if (Data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", Data); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b want 0", parity_err); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        tests++; if (rx_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", rx_done); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        rst = 1'b1;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3] = '{8'h0F, 8'hFF, 8'h0F};
        int hi0 = done_hi;
        int r0  = done_rise;
        Baud_set = 3'd0; parity_mode = 2'd0;
        for (int i = 0; i < 3; i++) send_frame(exp_d[i], 1'b0, 1'b0, 1'b1, c_BT0);
        #(c_BT0);
        @(negedge sysclk);
        tests++; if (done_rise - r0 !== 3) begin fails++; $display("FAIL b2b_pulses: got %0d want 3", done_rise - r0); end
        tests++; if (done_hi - hi0 !== 3) begin fails++; $display("FAIL b2b_pulse_cycles: got %0d want 3", done_hi - hi0); end
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            tests++; if (Data !== exp_d[i]) begin fails++; $display("FAIL b2b_data[%0d]: got %h want %h", i, Data, exp_d[i]); end
            tests++; if ({frame_err, parity_err} !== 2'b00) begin fails++; $display("FAIL b2b_flags[%0d]: got %b want 00", i, {frame_err, parity_err}); end
            do_pop();
        end
        @(negedge sysclk);
        tests++; if (rx_valid !== 1'b0 || Data !== 8'h00) begin fails++; $display("FAIL b2b_empty: valid %b data %h want 0 00", rx_valid, Data); end
    endtask

    task automatic test_parity();
        // 0x55 has four ones: even needs parity 0, odd needs parity 1
        logic [1:0] modes [3] = '{2'd1, 2'd1, 2'd2};
        logic       pbits [3] = '{1'b1, 1'b0, 1'b0};
        logic       exp_pe [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            parity_mode = modes[i];
            send_frame(8'h55, 1'b1, pbits[i], 1'b1, c_BT0);
            #(c_BT0 / 2);
            @(negedge sysclk);
            tests++; if (Data !== 8'h55 || rx_valid !== 1'b1) begin fails++; $display("FAIL parity_data[%0d]: got %h valid %b want 55 1", i, Data, rx_valid); end
            tests++; if (parity_err !== exp_pe[i] || frame_err !== 1'b0) begin fails++; $display("FAIL parity_flag[%0d]: got pe %b fe %b want pe %b fe 0", i, parity_err, frame_err, exp_pe[i]); end
            do_pop();
        end
        parity_mode = 2'd0;
    endtask

    task automatic test_glitch();
        int r0 = done_rise;
        @(negedge sysclk);
        uart_rx = 1'b0; #100; uart_rx = 1'b1;
        #(2 * c_BT0);
        @(negedge sysclk);
        tests++; if (done_rise !== r0 || rx_valid !== 1'b0) begin fails++; $display("FAIL glitch_100ns: done %0d valid %b want 0 0", done_rise - r0, rx_valid); end
        uart_rx = 1'b0; #3000; uart_rx = 1'b1;
        #(2 * c_BT0);
        @(negedge sysclk);
        tests++; if (done_rise !== r0 || rx_valid !== 1'b0) begin fails++; $display("FAIL glitch_3000ns: done %0d valid %b want 0 0", done_rise - r0, rx_valid); end
    endtask

    task automatic test_overrun();
        int r0 = done_rise;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1, c_BT0);
        @(negedge sysclk);
        tests++; if (overrun !== 1'b0 || rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_four: ovr %b valid %b want 0 1", overrun, rx_valid); end
        send_frame(8'h05, 1'b0, 1'b0, 1'b1, c_BT0);
        @(negedge sysclk);
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_fifth: got %b want 1", overrun); end
        tests++; if (done_rise - r0 !== 5) begin fails++; $display("FAIL ovr_pulses: got %0d want 5", done_rise - r0); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge sysclk);
            tests++; if (Data !== 8'(i)) begin fails++; $display("FAIL ovr_pop[%0d]: got %h want %h", i, Data, 8'(i)); end
            do_pop();
        end
        @(negedge sysclk);
        tests++; if (rx_valid !== 1'b0 || overrun !== 1'b1) begin fails++; $display("FAIL ovr_drained: valid %b ovr %b want 0 1", rx_valid, overrun); end
        clr_ovr = 1'b1;
        @(negedge sysclk);
        clr_ovr = 1'b0;
        @(negedge sysclk);
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_framing();
        int r0 = done_rise;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, c_BT0);
        #(2 * c_BT0);
        uart_rx = 1'b1;
        #(c_BT0);
        @(negedge sysclk);
        tests++; if (done_rise - r0 !== 1) begin fails++; $display("FAIL break_pulses: got %0d want 1", done_rise - r0); end
        tests++; if (Data !== 8'hA5 || frame_err !== 1'b1 || parity_err !== 1'b0) begin fails++; $display("FAIL break_head: got %h fe %b pe %b want a5 1 0", Data, frame_err, parity_err); end
        do_pop();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, c_BT0);
        @(negedge sysclk);
        tests++; if (Data !== 8'h3C || frame_err !== 1'b0 || parity_err !== 1'b0) begin fails++; $display("FAIL after_break: got %h fe %b pe %b want 3c 0 0", Data, frame_err, parity_err); end
        // 0x3C is left in the FIFO so the next reset has something to clear
    endtask

    task automatic test_reset_midframe();
        int r0;
        Baud_set = 3'd0;
        fork
            send_frame(8'h5A, 1'b0, 1'b0, 1'b1, c_BT0);
            begin
                #(4.5 * c_BT0);
                rst = 1'b0;
            end
        join
        r0 = done_rise;
        @(negedge sysclk);
        tests++; if ({Data, frame_err, parity_err, rx_valid, rx_done, overrun} !== 13'd0) begin fails++; $display("FAIL midreset_outputs: data %h fe %b pe %b valid %b done %b ovr %b want all 0", Data, frame_err, parity_err, rx_valid, rx_done, overrun); end
        rst = 1'b1;
        repeat (4) @(negedge sysclk);
        Baud_set = 3'd4;
        fork
            send_frame(8'h96, 1'b0, 1'b0, 1'b1, c_BT4);
            begin
                #(3 * c_BT4);
                Baud_set = 3'd0;
            end
        join
        @(negedge sysclk);
        tests++; if (done_rise - r0 !== 1) begin fails++; $display("FAIL slow_pulses: got %0d want 1", done_rise - r0); end
        tests++; if (Data !== 8'h96 || frame_err !== 1'b0 || parity_err !== 1'b0) begin fails++; $display("FAIL slow_head: got %h fe %b pe %b want 96 0 0", Data, frame_err, parity_err); end
        do_pop();
        @(negedge sysclk);
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL slow_empty: got %b want 0", rx_valid); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_parity();
        test_glitch();
        test_overrun();
        test_framing();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
